// File: rtl/masked_canright_bv8_inv_stage2_hpc1_pkg.sv
// Shared types and GF(2^4)/GF(2^2) helpers for the masked Canright S-box stages,
// all in Canright's normal basis: GF(4) on (W^2, W), GF(16) on (b^8, b^2) with N = W^2.
package masked_canright_bv8_inv_stage2_hpc1_pkg;

  typedef logic [3:0] bv4_t;
  typedef logic [1:0] bv2_t;

  function automatic int num_quad(input int n);
    return n * (n - 1) / 2;
  endfunction

  function automatic int num_zero_random(input int n);
    return n - 1;
  endfunction

  function automatic int stage_2_canright_hpc1_randoms(input int n);
    return 4 * (num_quad(n) + num_zero_random(n));
  endfunction

  // Index of the random word shared by the unordered share pair (i, j), i != j.
  function automatic int pair_index(input int i, input int j, input int n);
    int lo;
    int hi;
    lo = (i < j) ? i : j;
    hi = (i < j) ? j : i;
    return lo * n - lo * (lo + 1) / 2 + (hi - lo - 1);
  endfunction

  function automatic bv2_t gf4_mul(input bv2_t x, input bv2_t y);
    logic e;
    e = (x[1] ^ x[0]) & (y[1] ^ y[0]);
    return {(x[1] & y[1]) ^ e, (x[0] & y[0]) ^ e};
  endfunction

  function automatic bv2_t gf4_sq(input bv2_t x);
    return {x[0], x[1]};
  endfunction

  function automatic bv2_t gf4_scl_w(input bv2_t x);
    return {x[1] ^ x[0], x[1]};
  endfunction

  function automatic bv2_t gf4_scl_w2(input bv2_t x);
    return {x[0], x[1] ^ x[0]};
  endfunction

  function automatic bv4_t gf16_mul(input bv4_t x, input bv4_t y);
    bv2_t e;
    e = gf4_scl_w2(gf4_mul(x[3:2] ^ x[1:0], y[3:2] ^ y[1:0]));
    return {gf4_mul(x[3:2], y[3:2]) ^ e, gf4_mul(x[1:0], y[1:0]) ^ e};
  endfunction

  // Square then scale by nu = (0, W); collapses to a pure GF(2)-linear map.
  function automatic bv4_t gf16_sq_scl(input bv4_t x);
    return {gf4_sq(x[3:2] ^ x[1:0]), gf4_scl_w(gf4_sq(x[1:0]))};
  endfunction

  function automatic bv4_t canright_d(input bv4_t a1, input bv4_t a0);
    return gf16_sq_scl(a1 ^ a0) ^ gf16_mul(a1, a0);
  endfunction

endpackage

// File: rtl/masked_canright_bv8_inv_stage2_hpc1_gadgets.sv
// Reused masking building blocks: HPC1 multiplier, zero-sharing generator and a
// plain synchronous-reset register.
module masked_hpc1_mul
  import masked_canright_bv8_inv_stage2_hpc1_pkg::*;
#(
  parameter int NUM_SHARES = 2
) (
  input  logic                                in_clock,
  input  logic                                in_reset,
  input  bv4_t [NUM_SHARES-1:0]               in_a,
  input  bv4_t [NUM_SHARES-1:0]               in_b,
  input  logic [4*num_quad(NUM_SHARES)-1:0]   in_p,
  output bv4_t [NUM_SHARES-1:0]               out_c
);

  bv4_t [NUM_SHARES-1:0]                 b_t1;
  bv4_t [NUM_SHARES-1:0][NUM_SHARES-1:0] term_d;
  bv4_t [NUM_SHARES-1:0][NUM_SHARES-1:0] term_t2;

  // Cross products get the pair's random word before registering, so the
  // later XOR tree never sees an unmasked cross-share product.
  always_comb begin
    term_d = '0;
    for (int i = 0; i < NUM_SHARES; i++) begin
      for (int j = 0; j < NUM_SHARES; j++) begin
        term_d[i][j] = gf16_mul(in_a[i], b_t1[j]);
        if (i != j) begin
          term_d[i][j] = term_d[i][j] ^ in_p[4*pair_index(i, j, NUM_SHARES) +: 4];
        end
      end
    end
  end

  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      b_t1    <= '0;
      term_t2 <= '0;
    end else begin
      b_t1    <= in_b;
      term_t2 <= term_d;
    end
  end

  always_comb begin
    out_c = '0;
    for (int i = 0; i < NUM_SHARES; i++) begin
      for (int j = 0; j < NUM_SHARES; j++) begin
        out_c[i] = out_c[i] ^ term_t2[i][j];
      end
    end
  end

endmodule

module masked_zero
  import masked_canright_bv8_inv_stage2_hpc1_pkg::*;
#(
  parameter int NUM_SHARES = 2
) (
  input  logic [4*num_zero_random(NUM_SHARES)-1:0] in_r,
  output bv4_t [NUM_SHARES-1:0]                    out_z
);

  // Chain sharing of zero: each random word lands in two neighbouring shares.
  always_comb begin
    out_z = '0;
    for (int i = 0; i < NUM_SHARES - 1; i++) begin
      out_z[i]     = out_z[i]     ^ in_r[4*i +: 4];
      out_z[i + 1] = out_z[i + 1] ^ in_r[4*i +: 4];
    end
  end

endmodule

module register #(
  parameter int WIDTH = 1
) (
  input  logic             in_clock,
  input  logic             in_reset,
  input  logic [WIDTH-1:0] in_d,
  output logic [WIDTH-1:0] out_q
);

  always_ff @(posedge in_clock) begin
    if (in_reset) out_q <= '0;
    else          out_q <= in_d;
  end

endmodule

// File: rtl/masked_canright_bv8_inv_stage2_hpc1_sq_scl.sv
// Share-wise square-and-scale; linear, so each share is mapped on its own.
module masked_gf16_sq_scl
  import masked_canright_bv8_inv_stage2_hpc1_pkg::*;
#(
  parameter int NUM_SHARES = 2
) (
  input  bv4_t [NUM_SHARES-1:0] x,
  output bv4_t [NUM_SHARES-1:0] y
);

  for (genvar i = 0; i < NUM_SHARES; i++) begin : g_share
    assign y[i] = gf16_sq_scl(x[i]);
  end

endmodule

// File: rtl/masked_canright_bv8_inv_stage2_hpc1.sv
// Stage 2 of the masked Canright GF(2^8) inverter: d = sq_scl(a1^a0) ^ a1*a0, latency 2.
// Optional CANRIGHT_STAGE2_VALID_EN adds a valid shift register alongside the data.
module masked_canright_bv8_inv_stage2_hpc1
  import masked_canright_bv8_inv_stage2_hpc1_pkg::*;
#(
  parameter int NUM_SHARES = 2
) (
  input  logic                                             in_clock,
  input  logic                                             in_reset,
  input  bv4_t [1:0][NUM_SHARES-1:0]                       in_a_t0,
  input  logic [stage_2_canright_hpc1_randoms(NUM_SHARES)-1:0] in_random,
`ifdef CANRIGHT_STAGE2_VALID_EN
  input  logic                                             in_valid_t0,
  output logic                                             out_valid_t1,
  output logic                                             out_valid_t2,
`endif
  output bv4_t [1:0][NUM_SHARES-1:0]                       out_a_t1,
  output bv4_t [NUM_SHARES-1:0]                            out_d_t2
);

  localparam int P_BITS = 4 * num_quad(NUM_SHARES);
  localparam int R_BITS = 4 * num_zero_random(NUM_SHARES);

  logic [P_BITS-1:0]          p_mul;
  logic [R_BITS-1:0]          raw_r;
  bv4_t [NUM_SHARES-1:0]      zero_t0;
  bv4_t [NUM_SHARES-1:0]      a0_ref_t0;
  bv4_t [1:0][NUM_SHARES-1:0] a_t1;
  bv4_t [NUM_SHARES-1:0]      sum_t1;
  bv4_t [NUM_SHARES-1:0]      l_t1;
  bv4_t [NUM_SHARES-1:0]      l_t2;
  bv4_t [NUM_SHARES-1:0]      prod_t2;

  assign {p_mul, raw_r} = in_random;

  // a0 is refreshed before entering the gadget's internally registered b side.
  masked_zero #(.NUM_SHARES(NUM_SHARES)) u_zero (
    .in_r  (raw_r),
    .out_z (zero_t0)
  );

  assign a0_ref_t0 = in_a_t0[0] ^ zero_t0;

  register #(.WIDTH(8 * NUM_SHARES)) reg_a (
    .in_clock (in_clock),
    .in_reset (in_reset),
    .in_d     (in_a_t0),
    .out_q    (a_t1)
  );

  masked_hpc1_mul #(.NUM_SHARES(NUM_SHARES)) mul_a1a0 (
    .in_clock (in_clock),
    .in_reset (in_reset),
    .in_a     (a_t1[1]),
    .in_b     (a0_ref_t0),
    .in_p     (p_mul),
    .out_c    (prod_t2)
  );

  assign sum_t1 = a_t1[1] ^ a_t1[0];

  masked_gf16_sq_scl #(.NUM_SHARES(NUM_SHARES)) u_sq_scl (
    .x (sum_t1),
    .y (l_t1)
  );

  register #(.WIDTH(4 * NUM_SHARES)) reg_l (
    .in_clock (in_clock),
    .in_reset (in_reset),
    .in_d     (l_t1),
    .out_q    (l_t2)
  );

  assign out_a_t1 = a_t1;
  assign out_d_t2 = l_t2 ^ prod_t2;

`ifdef CANRIGHT_STAGE2_VALID_EN
  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      out_valid_t1 <= 1'b0;
      out_valid_t2 <= 1'b0;
    end else begin
      out_valid_t1 <= in_valid_t0;
      out_valid_t2 <= out_valid_t1;
    end
  end
`endif

endmodule

// File: tb/tb_masked_canright_bv8_inv_stage2_hpc1.sv
// Directed bench for stage 2 with 2- and 3-share instances driven by the same unshared stream;
// expected d values come from hand tables and an independent log-table GF(4) model.
module tb_masked_canright_bv8_inv_stage2_hpc1;
  import masked_canright_bv8_inv_stage2_hpc1_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  bv4_t [1:0][1:0] a2_t0;
  bv4_t [1:0][1:0] a2_t1;
  bv4_t [1:0]      d2_t2;
  bv4_t [1:0][2:0] a3_t0;
  bv4_t [1:0][2:0] a3_t1;
  bv4_t [2:0]      d3_t2;
  logic [stage_2_canright_hpc1_randoms(2)-1:0] rnd2;
  logic [stage_2_canright_hpc1_randoms(3)-1:0] rnd3;
`ifdef CANRIGHT_STAGE2_VALID_EN
  logic vld_t0;
  logic v2_t1, v2_t2, v3_t1, v3_t2;
`endif

  masked_canright_bv8_inv_stage2_hpc1 #(.NUM_SHARES(2)) dut2 (
    .in_clock     (clk),
    .in_reset     (rst),
    .in_a_t0      (a2_t0),
    .in_random    (rnd2),
`ifdef CANRIGHT_STAGE2_VALID_EN
    .in_valid_t0  (vld_t0),
    .out_valid_t1 (v2_t1),
    .out_valid_t2 (v2_t2),
`endif
    .out_a_t1     (a2_t1),
    .out_d_t2     (d2_t2)
  );

  masked_canright_bv8_inv_stage2_hpc1 #(.NUM_SHARES(3)) dut3 (
    .in_clock     (clk),
    .in_reset     (rst),
    .in_a_t0      (a3_t0),
    .in_random    (rnd3),
`ifdef CANRIGHT_STAGE2_VALID_EN
    .in_valid_t0  (vld_t0),
    .out_valid_t1 (v3_t1),
    .out_valid_t2 (v3_t2),
`endif
    .out_a_t1     (a3_t1),
    .out_d_t2     (d3_t2)
  );

  int total = 0;
  int bad = 0;

  // Hand-derived v*v and sq_scl(v) for v = 0..15.
  bv4_t sq_tab [16] = '{4'h0, 4'h7, 4'hE, 4'h9, 4'hD, 4'hA, 4'h3, 4'h4,
                        4'hB, 4'hC, 4'h5, 4'h2, 4'h6, 4'h1, 4'h8, 4'hF};
  bv4_t ss_tab [16] = '{4'h0, 4'hB, 4'h6, 4'hD, 4'h8, 4'h3, 4'hE, 4'h5,
                        4'h4, 4'hF, 4'h2, 4'h9, 4'hC, 4'h7, 4'hA, 4'h1};

  logic [7:0] m_a = 8'h00;
  bv4_t       m_dpend = 4'h0;
  bv4_t       m_d = 4'h0;
  logic       m_v1 = 1'b0;
  logic       m_v2 = 1'b0;

  function automatic int tb_gf4_log(input logic [1:0] x);
    case (x)
      2'b11:   return 0;
      2'b01:   return 1;
      default: return 2;
    endcase
  endfunction

  function automatic logic [1:0] tb_gf4_mul(input logic [1:0] x, input logic [1:0] y);
    int s;
    if (x == 2'b00 || y == 2'b00) return 2'b00;
    s = (tb_gf4_log(x) + tb_gf4_log(y)) % 3;
    case (s)
      0:       return 2'b11;
      1:       return 2'b01;
      default: return 2'b10;
    endcase
  endfunction

  function automatic bv4_t tb_gf16_mul(input bv4_t p, input bv4_t q);
    logic [1:0] e;
    e = tb_gf4_mul(2'b10, tb_gf4_mul(p[3:2] ^ p[1:0], q[3:2] ^ q[1:0]));
    return {tb_gf4_mul(p[3:2], q[3:2]) ^ e, tb_gf4_mul(p[1:0], q[1:0]) ^ e};
  endfunction

  function automatic bv4_t tb_model_d(input bv4_t a1, input bv4_t a0);
    return ss_tab[a1 ^ a0] ^ tb_gf16_mul(a1, a0);
  endfunction

  // Drive one cycle of fresh shares and randomness, then advance the expected pipeline.
  task automatic applyStimulus(input bv4_t a1, input bv4_t a0, input bv4_t exp_d,
                               input logic rst_in, input logic vld);
    bv4_t v;
    bv4_t m;
    rst = rst_in;
    for (int h = 0; h < 2; h++) begin
      v = (h == 1) ? a1 : a0;
      m = 4'($urandom);
      a2_t0[h][0] = m;
      a2_t0[h][1] = v ^ m;
      a3_t0[h][0] = 4'($urandom);
      a3_t0[h][1] = 4'($urandom);
      a3_t0[h][2] = v ^ a3_t0[h][0] ^ a3_t0[h][1];
    end
    rnd2 = 8'($urandom);
    rnd3 = 20'($urandom);
`ifdef CANRIGHT_STAGE2_VALID_EN
    vld_t0 = vld;
`endif
    @(posedge clk);
    m_d     = rst_in ? 4'h0 : m_dpend;
    m_dpend = rst_in ? 4'h0 : exp_d;
    m_a     = rst_in ? 8'h00 : {a1, a0};
    m_v2    = rst_in ? 1'b0 : m_v1;
    m_v1    = rst_in ? 1'b0 : vld;
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic raw_zero);
    logic [7:0] ua2, ua3;
    bv4_t       ud2, ud3;
    ua2 = {a2_t1[1][0] ^ a2_t1[1][1], a2_t1[0][0] ^ a2_t1[0][1]};
    ua3 = {a3_t1[1][0] ^ a3_t1[1][1] ^ a3_t1[1][2], a3_t1[0][0] ^ a3_t1[0][1] ^ a3_t1[0][2]};
    ud2 = d2_t2[0] ^ d2_t2[1];
    ud3 = d3_t2[0] ^ d3_t2[1] ^ d3_t2[2];
    total++;
    assert (ua2 === m_a) else begin
      bad++; $error("[TB] FAIL %s a_t1 N=2: got %h want %h", tag, ua2, m_a);
    end
    total++;
    assert (ua3 === m_a) else begin
      bad++; $error("[TB] FAIL %s a_t1 N=3: got %h want %h", tag, ua3, m_a);
    end
    total++;
    assert (ud2 === m_d) else begin
      bad++; $error("[TB] FAIL %s d_t2 N=2: got %h want %h (a_t1 %h)", tag, ud2, m_d, m_a);
    end
    total++;
    assert (ud3 === m_d) else begin
      bad++; $error("[TB] FAIL %s d_t2 N=3: got %h want %h (a_t1 %h)", tag, ud3, m_d, m_a);
    end
    if (raw_zero) begin
      total++;
      assert ({a2_t1, d2_t2, a3_t1, d3_t2} === '0) else begin
        bad++; $error("[TB] FAIL %s raw shares: got %h want 0", tag, {a2_t1, d2_t2, a3_t1, d3_t2});
      end
    end
`ifdef CANRIGHT_STAGE2_VALID_EN
    total++;
    assert ({v2_t1, v2_t2, v3_t1, v3_t2} === {m_v1, m_v2, m_v1, m_v2}) else begin
      bad++; $error("[TB] FAIL %s valid: got %b want %b", tag,
                    {v2_t1, v2_t2, v3_t1, v3_t2}, {m_v1, m_v2, m_v1, m_v2});
    end
`endif
  endtask

  initial begin
    logic [7:0] kv;
    bv4_t       r1, r0;
    rst = 1'b1;
    a2_t0 = '0;
    a3_t0 = '0;
    rnd2 = '0;
    rnd3 = '0;
`ifdef CANRIGHT_STAGE2_VALID_EN
    vld_t0 = 1'b0;
`endif
    $display("[TB] start");

    for (int c = 0; c < 3; c++) begin
      applyStimulus(4'($urandom), 4'($urandom), 4'h0, 1'b1, 1'b1);
      checkOutput("reset", 1'b1);
    end

    for (int c = 0; c < 3; c++) begin
      applyStimulus(4'h0, 4'h0, 4'h0, 1'b0, 1'b1);
      checkOutput("zero", 1'b0);
    end

    for (int v = 0; v < 16; v++) begin
      applyStimulus(4'(v), 4'(v), sq_tab[v], 1'b0, 1'b1);
      checkOutput("prod_only", 1'b0);
    end

    for (int v = 0; v < 16; v++) begin
      applyStimulus(4'h0, 4'(v), ss_tab[v], 1'b0, 1'b1);
      checkOutput("lin_only", 1'b0);
    end

    for (int k = 0; k < 256; k++) begin
      kv = 8'(k);
      applyStimulus(kv[7:4], kv[3:0], tb_model_d(kv[7:4], kv[3:0]), 1'b0, 1'b1);
      checkOutput("stream", 1'b0);
    end

    for (int c = 0; c < 4; c++) begin
      r1 = 4'($urandom);
      r0 = 4'($urandom);
      applyStimulus(r1, r0, tb_model_d(r1, r0), 1'b0, 1'b1);
      checkOutput("pre_rst", 1'b0);
    end
    applyStimulus(4'hA, 4'h5, tb_model_d(4'hA, 4'h5), 1'b1, 1'b1);
    checkOutput("mid_rst", 1'b1);
    for (int c = 0; c < 2; c++) begin
      r1 = 4'($urandom);
      r0 = 4'($urandom);
      applyStimulus(r1, r0, tb_model_d(r1, r0), 1'b0, 1'b0);
      checkOutput("post_rst_idle", 1'b0);
    end
    for (int c = 0; c < 5; c++) begin
      r1 = 4'($urandom);
      r0 = 4'($urandom);
      applyStimulus(r1, r0, tb_model_d(r1, r0), 1'b0, 1'b1);
      checkOutput("post_rst_run", 1'b0);
    end
    for (int c = 0; c < 2; c++) begin
      applyStimulus(4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
      checkOutput("drain", 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
